// File: rtl/sram_port_ctrl_pkg.sv
// Shared types and constants for the SRAM port controller.
package sram_port_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD0,
    RD1
  } state_e;

  localparam int unsigned STAT_WIDTH = 16;

endpackage

// File: rtl/sram_ctrl_sat_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sram_ctrl_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Request/response front end for a single-port synchronous SRAM with a shared tri-state bus.
// Optional statistics counters are enabled with SRAM_PORT_CTRL_STATS_EN.
module sram_port_ctrl
  import sram_port_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_wr,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
`ifdef SRAM_PORT_CTRL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_wr_cnt,
  output logic [STAT_WIDTH-1:0] stat_rd_cnt,
  output logic [STAT_WIDTH-1:0] stat_err_cnt
`endif
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cs_q, cs_d;
  logic                  wr_q, wr_d;
  logic                  oe_q, oe_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic accept;
  logic in_range;

  assign req_ready = ((state_q == IDLE) || (state_q == WR)) && !rsp_valid_q;
  assign accept    = req_valid && req_ready;
  assign in_range  = (32'(req_addr) < DEPTH);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE, WR: begin
        state_d = IDLE;
        if (accept) begin
          if (in_range) begin
            addr_d = req_addr;
            if (req_we) begin
              wdata_d = req_wdata;
              state_d = WR;
            end else begin
              state_d = RD0;
            end
          end else if (!req_we) begin
            // Out-of-range read answers immediately without touching the RAM.
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
            err_d       = 1'b1;
          end
        end
      end
      RD0: state_d = RD1;
      RD1: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rdata_d     = ram_data;
        err_d       = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // RAM pins are registered copies of the upcoming state's decode.
    cs_d = (state_d != IDLE);
    wr_d = (state_d == WR);
    oe_d = (state_d == RD1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_cs    = cs_q;
  assign ram_wr    = wr_q;
  assign ram_oe    = oe_q;
  assign ram_data  = wr_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef SRAM_PORT_CTRL_STATS_EN
  sram_ctrl_sat_cnt #(
    .WIDTH(STAT_WIDTH)
  ) u_wr_cnt (
    .clock(clock),
    .clear(reset),
    .inc  (wr_q),
    .count(stat_wr_cnt)
  );

  sram_ctrl_sat_cnt #(
    .WIDTH(STAT_WIDTH)
  ) u_rd_cnt (
    .clock(clock),
    .clear(reset),
    .inc  (oe_q),
    .count(stat_rd_cnt)
  );

  sram_ctrl_sat_cnt #(
    .WIDTH(STAT_WIDTH)
  ) u_err_cnt (
    .clock(clock),
    .clear(reset),
    .inc  (accept && !in_range),
    .count(stat_err_cnt)
  );
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed plus randomized bench for sram_port_ctrl against a behavioural SRAM and reference memory.
module tb_sram_port_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  logic          ram_cs;
  logic          ram_wr;
  logic          ram_oe;
  wire  [DW-1:0] ram_data;
`ifdef SRAM_PORT_CTRL_STATS_EN
  logic [15:0]   stat_wr_cnt;
  logic [15:0]   stat_rd_cnt;
  logic [15:0]   stat_err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_wr   = 0;
  int exp_rd   = 0;
  int exp_err  = 0;

  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] zz;

  always #5 clock = ~clock;

  sram_port_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .ram_addr (ram_addr),
    .ram_cs   (ram_cs),
    .ram_wr   (ram_wr),
    .ram_oe   (ram_oe),
    .ram_data (ram_data)
`ifdef SRAM_PORT_CTRL_STATS_EN
    ,
    .stat_wr_cnt (stat_wr_cnt),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_err_cnt(stat_err_cnt)
`endif
  );

  // Behavioural single-port synchronous RAM with registered output.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] mem_out;

  always @(posedge clock) begin
    if (ram_cs) begin
      if (ram_wr) mem[ram_addr] <= ram_data;
      else        mem_out       <= mem[ram_addr];
    end
  end

  assign ram_data = (ram_cs && !ram_wr && ram_oe) ? mem_out : {DW{1'bz}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_check();
    if (ram_wr || ram_oe) chk("bus_driven_known", 32'($isunknown(ram_data)), 32'd0);
    else                  chk("bus_high_z", ram_data, zz);
    if (ram_oe)           chk("oe_only_in_read", {ram_cs, ram_wr}, 2'b10);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    bus_check();
  endtask

  task automatic write1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("wr_req_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    if (int'(a) < DEPTH) begin
      chk("wr_pins", {ram_cs, ram_wr, ram_oe}, 3'b110);
      chk("wr_addr", ram_addr, a);
      chk("wr_data", ram_data, d);
      ref_mem[a] = d;
      exp_wr++;
    end else begin
      chk("wr_oor_no_cs", ram_cs, 1'b0);
      chk("wr_oor_no_rsp", rsp_valid, 1'b0);
      exp_err++;
    end
  endtask

  // Issues a read and checks timing up to rsp_valid; leaves the response pending.
  task automatic read_issue(input logic [AW-1:0] a);
    chk("rd_req_ready", req_ready, 1'b1);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    if (int'(a) >= DEPTH) begin
      chk("rd_oor_valid", rsp_valid, 1'b1);
      chk("rd_oor_err", rsp_err, 1'b1);
      chk("rd_oor_data", rsp_rdata, 16'h0);
      chk("rd_oor_no_cs", ram_cs, 1'b0);
      exp_err++;
    end else begin
      chk("rd0_pins", {ram_cs, ram_wr, ram_oe}, 3'b100);
      chk("rd0_addr", ram_addr, a);
      chk("rd0_no_rsp", rsp_valid, 1'b0);
      chk("rd0_not_ready", req_ready, 1'b0);
      tick();
      chk("rd1_pins", {ram_cs, ram_wr, ram_oe}, 3'b101);
      chk("rd1_bus", ram_data, ref_mem[a]);
      chk("rd1_no_rsp", rsp_valid, 1'b0);
      tick();
      chk("rd_valid", rsp_valid, 1'b1);
      chk("rd_data", rsp_rdata, ref_mem[a]);
      chk("rd_err", rsp_err, 1'b0);
      chk("rd_done_no_cs", ram_cs, 1'b0);
      exp_rd++;
    end
  endtask

  task automatic rsp_take();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] held;
    zz        = 'z;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 2 ** AW; i++) ref_mem[i] = '0;

    tick();
    tick();
    chk("rst_pins", {ram_cs, ram_wr, ram_oe}, 3'b000);
    chk("rst_addr", ram_addr, 4'h0);
    chk("rst_bus", ram_data, zz);
    chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst_rdata", rsp_rdata, 16'h0);
    reset = 1'b0;
    tick();
    chk("rst_req_ready", req_ready, 1'b1);

    // Single write then read of the same address.
    write1(4'd3, 16'hBEEF);
    tick();
    chk("wr_one_cycle", {ram_cs, ram_wr}, 2'b00);
    read_issue(4'd3);
    rsp_take();

    // Back-to-back writes, then reads straight out of the last WR cycle.
    for (int i = 0; i < 4; i++) write1(AW'(i), DW'(16'h1111 * (i + 1)));
    for (int i = 0; i < 4; i++) begin
      read_issue(AW'(i));
      rsp_take();
    end
    for (int i = 4; i < DEPTH; i++) write1(AW'(i), DW'($urandom));
    tick();

    // Held response: outputs stable, new requests blocked.
    read_issue(4'd5);
    held      = rsp_rdata;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'd0;
    req_wdata = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_data", rsp_rdata, held);
      chk("stall_not_ready", req_ready, 1'b0);
      chk("stall_no_cs", ram_cs, 1'b0);
    end
    req_valid = 1'b0;
    rsp_take();

    // Out-of-range write is dropped, out-of-range read errors at once.
    write1(4'd13, 16'hAAAA);
    tick();
    chk("oor_wr_no_cs", ram_cs, 1'b0);
    read_issue(4'd13);
    rsp_take();
`ifdef SRAM_PORT_CTRL_STATS_EN
    chk("stat_err", stat_err_cnt, 16'(exp_err));
`endif

    // Reset during RD0 abandons the read.
    read_issue_rd0: begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 4'd2;
      tick();
      req_valid = 1'b0;
      chk("mid_rd0_cs", ram_cs, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_pins", {ram_cs, ram_wr, ram_oe}, 3'b000);
      chk("mid_rst_addr", ram_addr, 4'h0);
      chk("mid_rst_bus", ram_data, zz);
      chk("mid_rst_no_rsp", rsp_valid, 1'b0);
      exp_wr  = 0;
      exp_rd  = 0;
      exp_err = 0;
      write1(4'd7, 16'h7777);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("mid_rst_never_rsp", rsp_valid, 1'b0);
      end
    end

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 2 ** AW - 1));
      if ($urandom_range(0, 1) == 1) begin
        write1(a, DW'($urandom));
      end else begin
        read_issue(a);
        rsp_take();
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();

`ifdef SRAM_PORT_CTRL_STATS_EN
    chk("stat_wr_final", stat_wr_cnt, 16'(exp_wr));
    chk("stat_rd_final", stat_rd_cnt, 16'(exp_rd));
    chk("stat_err_final", stat_err_cnt, 16'(exp_err));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
